// File: rtl/cond_issue_pipe.sv
// Two-stage conditional-compare issue pipe: S1 latches the request, S2 holds the 0/1 result.
// Optional macro SIGNED_CMP_EN enables signed codes 110 (A<B) and 111 (A>=B).
module cond_issue_pipe #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_code,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_c,
  output logic [15:0]      true_count,
  output logic             busy
);

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       code;
  } req_t;

  req_t             s1_q, s1_d;
  logic             s1_v_q, s1_v_d;
  logic             s2_v_q, s2_v_d;
  logic [WIDTH-1:0] s2_c_q, s2_c_d;
  logic [15:0]      cnt_q, cnt_d;
  logic             cond;
  logic             in_hs, out_hs, s2_load;

  always_comb begin
    cond = 1'b0;
    case (s1_q.code)
      3'b000: cond = (s1_q.a <= s1_q.b);
      3'b001: cond = (s1_q.a <  s1_q.b);
      3'b010: cond = (s1_q.a >= s1_q.b);
      3'b011: cond = (s1_q.a >  s1_q.b);
      3'b100: cond = (s1_q.a == s1_q.b);
      3'b101: cond = (s1_q.a != s1_q.b);
`ifdef SIGNED_CMP_EN
      3'b110: cond = ($signed(s1_q.a) <  $signed(s1_q.b));
      3'b111: cond = ($signed(s1_q.a) >= $signed(s1_q.b));
`else
      3'b110: cond = 1'b0;
      3'b111: cond = 1'b0;
`endif
      default: cond = 1'b0;
    endcase
  end

  always_comb begin
    out_hs   = s2_v_q & out_ready;
    s2_load  = s1_v_q & (~s2_v_q | out_hs);
    // Held low during reset so nothing is accepted into a stage being cleared.
    in_ready = ~rst & (~s1_v_q | s2_load);
    in_hs    = in_valid & in_ready;

    s1_d   = in_hs ? '{a: in_a, b: in_b, code: in_code} : s1_q;
    s1_v_d = in_hs | (s1_v_q & ~s2_load);
    s2_v_d = s2_load | (s2_v_q & ~out_hs);
    s2_c_d = s2_load ? WIDTH'(cond) : s2_c_q;

    cnt_d = cnt_q;
    if (out_hs && s2_c_q[0] && (cnt_q != 16'hFFFF))
      cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q   <= '0;
      s1_v_q <= 1'b0;
      s2_v_q <= 1'b0;
      s2_c_q <= '0;
      cnt_q  <= '0;
    end else begin
      s1_q   <= s1_d;
      s1_v_q <= s1_v_d;
      s2_v_q <= s2_v_d;
      s2_c_q <= s2_c_d;
      cnt_q  <= cnt_d;
    end
  end

  assign out_valid  = s2_v_q;
  assign out_c      = s2_c_q;
  assign true_count = cnt_q;
  assign busy       = s1_v_q | s2_v_q;

endmodule

// File: tb/tb_cond_issue_pipe.sv
// Bench for cond_issue_pipe: vector table plus hand sequences, scoreboarded at the output.
module tb_cond_issue_pipe;
`ifdef SIGNED_CMP_EN
  localparam bit SG = 1'b1;
`else
  localparam bit SG = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_a = '0, in_b = '0;
  logic [2:0]  in_code = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_c;
  logic [15:0] true_count;
  logic        busy;

  cond_issue_pipe #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_code(in_code), .out_valid(out_valid),
    .out_ready(out_ready), .out_c(out_c), .true_count(true_count), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [2:0]  code;
    logic        exp;
  } vec_t;

  vec_t        vecs[16];
  bit          sb[$];
  bit          exp_cur;
  logic [15:0] exp_cnt = '0;
  int          n_chk = 0, n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Scoreboard: outputs consumed against queued expectations, count modelled from them.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      exp_cnt = '0;
    end else begin
      chk("true_count", 32'(true_count), 32'(exp_cnt));
      if (out_valid && out_ready) begin
        if (sb.size() == 0) chk("unexpected_out", 32'(out_valid), 32'd0);
        else begin
          automatic bit e = sb.pop_front();
          chk("out_c", 32'(out_c), 32'(e));
          if (e && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
        end
      end
      if (in_valid && in_ready) sb.push_back(exp_cur);
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic drive(input logic [15:0] a, input logic [15:0] b, input logic [2:0] code,
                       input bit e);
    in_a = a; in_b = b; in_code = code; exp_cur = e; in_valid = 1'b1;
  endtask

  task automatic wait_acc(output bit first);
    bit done = 1'b0;
    first = 1'b1;
    for (int t = 0; t < 50 && !done; t++) begin
      @(negedge clk);
      done = in_ready;
      if (!done) first = 1'b0;
      step();
    end
    if (!done) chk("accept_timeout", 32'(done), 32'd1);
  endtask

  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [2:0] code,
                      input bit e, output bit first);
    drive(a, b, code, e);
    wait_acc(first);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 30 && (sb.size() != 0 || busy); t++) step();
    chk("drain", 32'(sb.size() == 0 && !busy), 32'd1);
  endtask

  initial begin
    bit first;
    bit all_first;
    logic [15:0] oc;
    int ones;

    vecs[0]  = '{16'd3,    16'd3,    3'd4, 1'b1};
    vecs[1]  = '{16'd3,    16'd3,    3'd5, 1'b0};
    vecs[2]  = '{16'd9,    16'd2,    3'd3, 1'b1};
    vecs[3]  = '{16'd7,    16'd7,    3'd0, 1'b1};
    vecs[4]  = '{16'd8,    16'd7,    3'd0, 1'b0};
    vecs[5]  = '{16'd7,    16'd7,    3'd1, 1'b0};
    vecs[6]  = '{16'd7,    16'd7,    3'd2, 1'b1};
    vecs[7]  = '{16'd6,    16'd7,    3'd2, 1'b0};
    vecs[8]  = '{16'd7,    16'd7,    3'd3, 1'b0};
    vecs[9]  = '{16'hFFFF, 16'h0001, 3'd6, SG};
    vecs[10] = '{16'hFFFF, 16'h0001, 3'd3, 1'b1};
    vecs[11] = '{16'h0001, 16'hFFFF, 3'd7, SG};
    vecs[12] = '{16'h8000, 16'h7FFF, 3'd7, 1'b0};
    vecs[13] = '{16'h0000, 16'h0000, 3'd6, 1'b0};
    vecs[14] = '{16'h8000, 16'h7FFF, 3'd1, 1'b0};
    vecs[15] = '{16'h1234, 16'h1235, 3'd5, 1'b1};

    // Reset state
    #3;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_true_count", 32'(true_count), 32'd0);
    chk("rst_out_c", 32'(out_c), 32'd0);
    step(); step();
    rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("in_ready_after_rst", 32'(in_ready), 32'd1);

    // Single request latency: accepted at edge N, out_valid after N+1
    step();
    drive(16'd5, 16'd7, 3'd1, 1'b1);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("lat_s1_only", 32'(out_valid), 32'd0);
    chk("lat_busy", 32'(busy), 32'd1);
    @(negedge clk);
    chk("lat_out_valid", 32'(out_valid), 32'd1);
    chk("lat_out_c", 32'(out_c), 32'd1);
    step();
    @(negedge clk);
    chk("lat_count", 32'(true_count), 32'd1);
    step();

    // Back-to-back table stream at full rate
    all_first = 1'b1;
    ones = 1;
    foreach (vecs[i]) begin
      send(vecs[i].a, vecs[i].b, vecs[i].code, vecs[i].exp, first);
      if (!first) all_first = 1'b0;
      ones += int'(vecs[i].exp);
    end
    chk("stream_in_ready", 32'(all_first), 32'd1);
    drain();
    chk("count_after_table", 32'(true_count), 32'(ones));

    // Back-pressure: two accepted, third stalls, output held
    out_ready = 1'b0;
    send(16'd3, 16'd3, 3'd4, 1'b1, first);
    send(16'd3, 16'd3, 3'd5, 1'b0, first);
    drive(16'd9, 16'd2, 3'd3, 1'b1);
    @(negedge clk);
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    chk("bp_out_valid", 32'(out_valid), 32'd1);
    oc = out_c;
    for (int k = 0; k < 3; k++) begin
      step();
      @(negedge clk);
      chk("bp_out_c_stable", 32'(out_c), 32'(oc));
      chk("bp_in_ready_held", 32'(in_ready), 32'd0);
    end
    step();
    out_ready = 1'b1;
    wait_acc(first);
    in_valid = 1'b0;
    drain();
    chk("count_after_bp", 32'(true_count), 32'(ones + 2));

    // Asynchronous reset mid-stream with both stages full
    out_ready = 1'b0;
    send(16'd1, 16'd1, 3'd4, 1'b1, first);
    send(16'd2, 16'd2, 3'd4, 1'b1, first);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_count", 32'(true_count), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
    step();
    rst = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("no_stale_out", 32'(out_valid), 32'd0);
      step();
    end

    // Saturation of true_count
    for (int k = 0; k < 65537; k++) send(16'd0, 16'd0, 3'd4, 1'b1, first);
    drain();
    chk("count_saturated", 32'(true_count), 32'h0000FFFF);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/cond_issue_pipe.md
COND_ISSUE_PIPE -- requirements
Module: cond_issue_pipe

Interface
REQ-001 The block SHALL have one clock and an asynchronous active-high reset: clk  input  1  rising-edge clock; rst  input  1  asynchronous active-high reset.
REQ-002 Parameter: WIDTH, default 16, operand and result width.
REQ-003 Port: in_valid  input  1  request valid.
REQ-004 Port: in_ready  output  1  block accepts a request this cycle.
REQ-005 Port: in_a  input  WIDTH  operand A.
REQ-006 Port: in_b  input  WIDTH  operand B.
REQ-007 Port: in_code  input  3  compare code.
REQ-008 Port: out_valid  output  1  result valid.
REQ-009 Port: out_ready  input  1  consumer accepts the result.
REQ-010 Port: out_c  output  WIDTH  result: 1 if the condition is true, else 0, zero-extended.
REQ-011 Port: true_count  output  16  saturating count of delivered results equal to 1.
REQ-012 Port: busy  output  1  at least one pipeline stage holds valid data.

Function
REQ-013 Compare codes (unsigned): 000 A<=B; 001 A<B; 010 A>=B; 011 A>B; 100 A==B; 101 A!=B. Code 110 and code 111 without SIGNED_CMP_EN SHALL produce 0.
REQ-014 Two registered stages: S1 captures {a,b,code} on in handshake; S2 holds the computed out_c; out_c SHALL be driven only from the S2 register.
REQ-015 Transfers: in handshake = in_valid & in_ready; out handshake = out_valid & out_ready.
REQ-016 Latency: a request accepted at edge N SHALL be presented as out_valid=1 after edge N+1 when there is no back-pressure.
REQ-017 Throughput: one request per cycle SHALL be sustained while out_ready=1.
REQ-018 S2 SHALL load from S1 when S1 is valid and (S2 is empty or an out handshake occurs in the same cycle).
REQ-019 in_ready SHALL be 1 when S1 is empty or S1 advances into S2 in the same cycle; it is combinational and SHALL NOT depend on in_valid.
REQ-020 With out_ready=0 and both stages full, in_ready=0; S1 and S2 contents SHALL hold unchanged, and out_c SHALL stay stable while out_valid=1.
REQ-021 Simultaneous in and out handshakes with both stages full SHALL shift without a bubble and without data loss.
REQ-022 true_count SHALL increment by 1 on each out handshake where out_c==1, and SHALL saturate at 16'hFFFF.
REQ-023 busy SHALL equal (S1 valid | S2 valid).
REQ-024 Requests SHALL leave the block in acceptance order; no request is dropped or duplicated.

Reset
REQ-025 While rst=1, S1 valid, S2 valid, out_valid, out_c, true_count and busy SHALL all be 0, asynchronously.
REQ-026 While rst=1, in_ready SHALL be 0; in-flight requests SHALL be discarded.
REQ-027 in_ready SHALL be 1 in the first cycle after rst deasserts.

Configuration
REQ-028 Macro SIGNED_CMP_EN: when defined, code 110 SHALL give signed A<B and code 111 SHALL give signed A>=B (two's complement, WIDTH bits).
REQ-029 When SIGNED_CMP_EN is undefined, codes 110 and 111 SHALL produce out_c=0 and SHALL still be transferred and handshaked normally.

Verification
REQ-030 Reset, then send A=5, B=7, code 001 with out_ready=1 -> out_valid two edges later, out_c=16'h0001, true_count=1.
REQ-031 Back-to-back stream (A=3,B=3,code 100), (A=3,B=3,code 101), (A=9,B=2,code 011) with out_ready=1 -> outputs 1, 0, 1 on consecutive cycles; in_ready stays 1; true_count=2.
REQ-032 Hold out_ready=0 and send three requests -> two are accepted, in_ready=0 on the third, out_c stable; then raise out_ready -> all three are delivered in order.
REQ-033 Send A=16'hFFFF, B=16'h0001, code 110 -> 1 with SIGNED_CMP_EN defined, 0 without it; the same operands with code 011 -> 1 in both builds.
REQ-034 Assert rst mid-stream with both stages full -> out_valid, busy and true_count go to 0 immediately; no stale result is delivered after release.
REQ-035 Preload via 65535 true results, then send one more true result -> true_count stays at 16'hFFFF.
